// File: rtl/trap_pkg.sv
// trap_pkg: shared definitions for the machine-mode trap sequencer.
//   - CSR addresses for the M-mode trap CSRs
//   - mcause values for ecall-from-M and machine timer interrupt
//   - mstatus bit positions (MIE, MPIE, MPP)
//   - sequencer FSM state encoding
package trap_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam logic [63:0] CAUSE_ECALL_M_DEF = 64'd11;
    localparam logic [63:0] CAUSE_MTI_DEF     = 64'h8000_0000_0000_0007;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        W_MEPC    = 3'd1,
        W_MCAUSE  = 3'd2,
        W_MSTATUS = 3'd3,
        REDIRECT  = 3'd4,
        R_MSTATUS = 3'd5
    } state_e;

endpackage

// File: rtl/trap_sequencer_mstatus_xform.sv
// mstatus_xform: combinational mstatus rewrite for trap entry / mret.
//   i_mode   0 = trap entry : MPIE<=MIE, MIE<=0, MPP<=M
//            1 = mret       : MIE<=MPIE, MPIE<=1, MPP<=M
//   i_status mstatus value captured when the event was accepted
//   o_status rewritten mstatus to write back
module mstatus_xform
    import trap_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            i_mode,
    input  logic [XLEN-1:0] i_status,
    output logic [XLEN-1:0] o_status
);

    always_comb begin
        o_status = i_status;
        if (!i_mode) begin
            o_status[MSTATUS_MPIE] = i_status[MSTATUS_MIE];
            o_status[MSTATUS_MIE]  = 1'b0;
        end else begin
            o_status[MSTATUS_MIE]  = i_status[MSTATUS_MPIE];
            o_status[MSTATUS_MPIE] = 1'b1;
        end
        // Only M-mode exists in this core, so MPP is always M.
        o_status[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end

endmodule

// File: rtl/trap_sequencer.sv
// trap_sequencer: sequences M-mode trap entry (ecall, timer interrupt) and
// mret around the single-write-port CSR file, one CSR write per cycle,
// then redirects fetch through a valid/ready handshake and flushes.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   i_commit_valid/pc          instruction at the commit boundary and its PC
//   i_commit_ecall/mret        committing instruction class
//   i_mtip, i_mie_mtie         timer interrupt pending / enabled
//   i_mstatus, i_mtvec, i_mepc current CSR values
//   i_redirect_ready           fetch accepts redirect
//   o_stall, o_flush           pipeline hold / one-cycle flush
//   o_csr_wen/waddr/wdata      CSR write port
//   o_redirect_valid/pc        redirect request to fetch
//   o_busy                     sequence in progress
module trap_sequencer
    import trap_pkg::*;
#(
    parameter int              XLEN          = 64,
    parameter logic [XLEN-1:0] CAUSE_ECALL_M = CAUSE_ECALL_M_DEF,
    parameter logic [XLEN-1:0] CAUSE_MTI     = CAUSE_MTI_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_commit_valid,
    input  logic [XLEN-1:0] i_commit_pc,
    input  logic            i_commit_ecall,
    input  logic            i_commit_mret,
    input  logic            i_mtip,
    input  logic [XLEN-1:0] i_mstatus,
    input  logic            i_mie_mtie,
    input  logic [XLEN-1:0] i_mtvec,
    input  logic [XLEN-1:0] i_mepc,
    input  logic            i_redirect_ready,
    output logic            o_stall,
    output logic            o_flush,
    output logic            o_csr_wen,
    output logic [11:0]     o_csr_waddr,
    output logic [XLEN-1:0] o_csr_wdata,
    output logic            o_redirect_valid,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic            o_busy
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] epc_q, cause_q, status_q, target_q;
    logic [XLEN-1:0] status_xf;
    logic            irq, can_accept, take_trap, take_mret, accept;

    // Events are only sampled in IDLE with a committing instruction. rst_n
    // gates acceptance so the combinational stall cannot leak out while the
    // block is held in reset.
    assign irq        = i_mstatus[MSTATUS_MIE] & i_mie_mtie & i_mtip;
    assign can_accept = rst_n & (state_q == IDLE) & i_commit_valid;
    // Interrupt beats ecall beats mret; ecall+mret together resolves to ecall.
    assign take_trap  = can_accept & (irq | i_commit_ecall);
    assign take_mret  = can_accept & ~irq & ~i_commit_ecall & i_commit_mret;
    assign accept     = take_trap | take_mret;

    mstatus_xform #(.XLEN(XLEN)) u_xform (
        .i_mode   (state_q == R_MSTATUS),
        .i_status (status_q),
        .o_status (status_xf)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Event capture: everything the sequence writes is frozen at accept, so
    // later changes on the CSR inputs cannot disturb a sequence in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            epc_q    <= '0;
            cause_q  <= '0;
            status_q <= '0;
            target_q <= '0;
        end else if (accept) begin
            epc_q    <= i_commit_pc;
            status_q <= i_mstatus;
            cause_q  <= irq ? CAUSE_MTI : (i_commit_ecall ? CAUSE_ECALL_M : '0);
            // Direct mode only: drop the mtvec MODE field.
            target_q <= take_trap ? {i_mtvec[XLEN-1:2], 2'b00} : i_mepc;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (take_trap)      state_d = W_MEPC;
                else if (take_mret) state_d = R_MSTATUS;
            end
            W_MEPC:    state_d = W_MCAUSE;
            W_MCAUSE:  state_d = W_MSTATUS;
            W_MSTATUS: state_d = REDIRECT;
            R_MSTATUS: state_d = REDIRECT;
            REDIRECT:  if (i_redirect_ready) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        o_busy           = (state_q != IDLE);
        o_stall          = o_busy | accept;
        o_flush          = 1'b0;
        o_csr_wen        = 1'b0;
        o_csr_waddr      = '0;
        o_csr_wdata      = '0;
        o_redirect_valid = 1'b0;
        o_redirect_pc    = '0;
        case (state_q)
            W_MEPC: begin
                o_csr_wen   = 1'b1;
                o_csr_waddr = CSR_MEPC;
                o_csr_wdata = epc_q;
            end
            W_MCAUSE: begin
                o_csr_wen   = 1'b1;
                o_csr_waddr = CSR_MCAUSE;
                o_csr_wdata = cause_q;
            end
            W_MSTATUS, R_MSTATUS: begin
                o_csr_wen   = 1'b1;
                o_csr_waddr = CSR_MSTATUS;
                o_csr_wdata = status_xf;
            end
            REDIRECT: begin
                o_redirect_valid = 1'b1;
                o_redirect_pc    = target_q;
                // Flush on the handshake so fetch and flush line up exactly.
                o_flush          = i_redirect_ready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_trap_sequencer.sv
module tb_trap_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_commit_valid, i_commit_ecall, i_commit_mret;
    logic [63:0] i_commit_pc, i_mstatus, i_mtvec, i_mepc;
    logic        i_mtip, i_mie_mtie, i_redirect_ready;
    logic        o_stall, o_flush, o_csr_wen, o_redirect_valid, o_busy;
    logic [11:0] o_csr_waddr;
    logic [63:0] o_csr_wdata, o_redirect_pc;

    int checks = 0;
    int errors = 0;

    trap_sequencer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_commit_valid   (i_commit_valid),
        .i_commit_pc      (i_commit_pc),
        .i_commit_ecall   (i_commit_ecall),
        .i_commit_mret    (i_commit_mret),
        .i_mtip           (i_mtip),
        .i_mstatus        (i_mstatus),
        .i_mie_mtie       (i_mie_mtie),
        .i_mtvec          (i_mtvec),
        .i_mepc           (i_mepc),
        .i_redirect_ready (i_redirect_ready),
        .o_stall          (o_stall),
        .o_flush          (o_flush),
        .o_csr_wen        (o_csr_wen),
        .o_csr_waddr      (o_csr_waddr),
        .o_csr_wdata      (o_csr_wdata),
        .o_redirect_valid (o_redirect_valid),
        .o_redirect_pc    (o_redirect_pc),
        .o_busy           (o_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; return 2 time units after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_commit();
        i_commit_valid = 1'b0;
        i_commit_ecall = 1'b0;
        i_commit_mret  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_commit();
        i_commit_pc = '0; i_mstatus = '0; i_mtvec = '0; i_mepc = '0;
        i_mtip = 1'b0; i_mie_mtie = 1'b0; i_redirect_ready = 1'b0;

        // ---- reset state
        tick(); tick();
        chk("rst_stall", 64'(o_stall), 64'd0);
        chk("rst_busy",  64'(o_busy),  64'd0);
        chk("rst_wen",   64'(o_csr_wen), 64'd0);
        chk("rst_rv",    64'(o_redirect_valid), 64'd0);
        chk("rst_flush", 64'(o_flush), 64'd0);
        rst_n = 1'b1;
        tick();

        // ---- ecall, ready held high
        i_commit_valid = 1'b1; i_commit_ecall = 1'b1; i_commit_pc = 64'h8000_0010;
        i_mstatus = 64'h8; i_mtvec = 64'h8000_0101; i_redirect_ready = 1'b1;
        #1;
        chk("ec_accept_stall", 64'(o_stall), 64'd1);
        chk("ec_accept_wen",   64'(o_csr_wen), 64'd0);
        tick(); clear_commit();
        chk("ec_mepc_wen",   64'(o_csr_wen), 64'd1);
        chk("ec_mepc_addr",  64'(o_csr_waddr), 64'h341);
        chk("ec_mepc_data",  o_csr_wdata, 64'h8000_0010);
        chk("ec_stall1",     64'(o_stall), 64'd1);
        chk("ec_busy1",      64'(o_busy), 64'd1);
        tick();
        chk("ec_mcause_addr", 64'(o_csr_waddr), 64'h342);
        chk("ec_mcause_data", o_csr_wdata, 64'd11);
        chk("ec_stall2",      64'(o_stall), 64'd1);
        tick();
        chk("ec_mst_addr", 64'(o_csr_waddr), 64'h300);
        chk("ec_mst_data", o_csr_wdata, 64'h1880);
        chk("ec_stall3",   64'(o_stall), 64'd1);
        chk("ec_rv_early", 64'(o_redirect_valid), 64'd0);
        tick();
        chk("ec_rv",     64'(o_redirect_valid), 64'd1);
        chk("ec_rpc",    o_redirect_pc, 64'h8000_0100);
        chk("ec_flush",  64'(o_flush), 64'd1);
        chk("ec_rd_wen", 64'(o_csr_wen), 64'd0);
        chk("ec_stall4", 64'(o_stall), 64'd1);
        tick();
        chk("ec_idle_flush", 64'(o_flush), 64'd0);
        chk("ec_idle_stall", 64'(o_stall), 64'd0);
        chk("ec_idle_busy",  64'(o_busy), 64'd0);

        // ---- mret
        i_commit_valid = 1'b1; i_commit_mret = 1'b1; i_commit_pc = 64'h8000_0100;
        i_mepc = 64'h8000_0014; i_mstatus = 64'h1880;
        #1;
        chk("mr_accept_stall", 64'(o_stall), 64'd1);
        tick(); clear_commit();
        chk("mr_wen",  64'(o_csr_wen), 64'd1);
        chk("mr_addr", 64'(o_csr_waddr), 64'h300);
        chk("mr_data", o_csr_wdata, 64'h1888);
        tick();
        chk("mr_rv",    64'(o_redirect_valid), 64'd1);
        chk("mr_rpc",   o_redirect_pc, 64'h8000_0014);
        chk("mr_flush", 64'(o_flush), 64'd1);
        chk("mr_wen2",  64'(o_csr_wen), 64'd0);
        tick();
        chk("mr_idle_busy", 64'(o_busy), 64'd0);

        // ---- timer interrupt beats a committing ecall
        i_mtip = 1'b1; i_mie_mtie = 1'b1; i_mstatus = 64'h8;
        i_commit_valid = 1'b1; i_commit_ecall = 1'b1; i_commit_pc = 64'h8000_0020;
        tick(); clear_commit(); i_mtip = 1'b0;
        chk("irq_mepc", o_csr_wdata, 64'h8000_0020);
        tick();
        chk("irq_mcause", o_csr_wdata, 64'h8000_0000_0000_0007);
        tick();
        chk("irq_mst", o_csr_wdata, 64'h1880);
        tick();
        chk("irq_rpc", o_redirect_pc, 64'h8000_0100);
        tick();
        chk("irq_idle", 64'(o_busy), 64'd0);

        // ---- masking: MIE=0 or MTIE=0 over 10 commits, no event
        i_mtip = 1'b1;
        for (int k = 0; k < 10; k++) begin
            i_commit_valid = 1'b1;
            i_commit_pc    = 64'h8000_0040 + 64'(4 * k);
            i_mstatus      = (k % 2 == 0) ? 64'h0 : 64'h8;
            i_mie_mtie     = (k % 2 == 0);
            #1;
            chk("mask_stall", 64'(o_stall), 64'd0);
            tick();
            chk("mask_wen",  64'(o_csr_wen), 64'd0);
            chk("mask_busy", 64'(o_busy), 64'd0);
        end
        clear_commit(); i_mtip = 1'b0; i_mie_mtie = 1'b0;
        tick();

        // ---- redirect back-pressure
        i_redirect_ready = 1'b0;
        i_commit_valid = 1'b1; i_commit_ecall = 1'b1; i_commit_pc = 64'h8000_0030;
        i_mstatus = 64'h0; i_mtvec = 64'h8000_0202;
        tick(); clear_commit();
        i_mtvec = 64'h0;   // target must already be captured
        tick(); tick(); tick();
        for (int k = 0; k < 5; k++) begin
            chk("bp_rv",    64'(o_redirect_valid), 64'd1);
            chk("bp_rpc",   o_redirect_pc, 64'h8000_0200);
            chk("bp_flush", 64'(o_flush), 64'd0);
            chk("bp_stall", 64'(o_stall), 64'd1);
            tick();
        end
        i_redirect_ready = 1'b1;
        #1;
        chk("bp_hs_flush", 64'(o_flush), 64'd1);
        chk("bp_hs_rpc",   o_redirect_pc, 64'h8000_0200);
        tick();
        chk("bp_post_flush", 64'(o_flush), 64'd0);
        chk("bp_post_busy",  64'(o_busy), 64'd0);

        // ---- reset mid-sequence in W_MCAUSE
        i_commit_valid = 1'b1; i_commit_ecall = 1'b1; i_commit_pc = 64'h8000_0050;
        i_mstatus = 64'h8; i_mtvec = 64'h8000_0100;
        tick(); clear_commit();
        tick();
        chk("rs_in_mcause", 64'(o_csr_waddr), 64'h342);
        rst_n = 1'b0;
        #1;
        chk("rs_stall", 64'(o_stall), 64'd0);
        chk("rs_busy",  64'(o_busy), 64'd0);
        chk("rs_wen",   64'(o_csr_wen), 64'd0);
        chk("rs_addr",  64'(o_csr_waddr), 64'h0);
        chk("rs_data",  o_csr_wdata, 64'h0);
        chk("rs_rv",    64'(o_redirect_valid), 64'd0);
        chk("rs_flush", 64'(o_flush), 64'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rs_post_wen",  64'(o_csr_wen), 64'd0);
            chk("rs_post_busy", 64'(o_busy), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Controller that sequences machine-mode trap entry (ecall, machine timer interrupt) and trap return (mret) around the single-write-port CSR file inside the decode stage.
- Serialises the multi-CSR update (mepc, mcause, mstatus) into one write per cycle.
- Stalls and flushes the pipeline, then issues a PC redirect to fetch through a valid/ready handshake.
- Sits between commit/writeback and the IF/ID CSR write port; it replaces the ad-hoc ecall/mret write muxing.

Parameters:
- XLEN, 64, data/PC width.
- CAUSE_ECALL_M, 64'd11, mcause value for ecall from M-mode.
- CAUSE_MTI, 64'h8000_0000_0000_0007, mcause value for machine timer interrupt.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  async active-low reset.
- i_commit_valid  in  1  an instruction is at the commit boundary this cycle.
- i_commit_pc  in  XLEN  PC of that instruction.
- i_commit_ecall  in  1  committing instruction is ecall.
- i_commit_mret  in  1  committing instruction is mret.
- i_mtip  in  1  timer interrupt pending, from CLINT.
- i_mstatus  in  XLEN  current mstatus.
- i_mie_mtie  in  1  mie.MTIE.
- i_mtvec  in  XLEN  current mtvec (direct mode only).
- i_mepc  in  XLEN  current mepc.
- i_redirect_ready  in  1  fetch accepts redirect.
- o_stall  out  1  hold commit/fetch.
- o_flush  out  1  one-cycle pipeline flush.
- o_csr_wen  out  1  CSR write enable.
- o_csr_waddr  out  12  CSR write address.
- o_csr_wdata  out  XLEN  CSR write data.
- o_redirect_valid  out  1  redirect request.
- o_redirect_pc  out  XLEN  redirect target.
- o_busy  out  1  FSM not IDLE.

Behaviour:
- Reset: asynchronous, active-low. FSM goes to IDLE. All outputs 0. Internal latches (epc, cause, status, target) go to 0. Reset mid-sequence aborts with no further CSR writes.
- States: IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, REDIRECT, R_MSTATUS.
- IDLE event priority (sampled when i_commit_valid=1):
  - Interrupt: i_mstatus[3] & i_mie_mtie & i_mtip.
  - Then ecall.
  - Then mret.
  - Interrupt wins over a simultaneous ecall/mret. The instruction is not executed and mepc = i_commit_pc.
- On accept: o_stall=1 combinationally in the same cycle. Latch epc=i_commit_pc, status=i_mstatus, cause.
- Trap entry: next state W_MEPC.
- Trap entry target: i_mtvec & ~64'h3, latched at accept.
- mret: next state R_MSTATUS. Target = i_mepc, latched at accept.
- W_MEPC: wen=1, addr 12'h341, data=epc. Then W_MCAUSE.
- W_MCAUSE: wen=1, addr 12'h342, data=cause. Then W_MSTATUS.
- W_MSTATUS (entry): wen=1, addr 12'h300, data=status with MPIE[7]=status[3], MIE[3]=0, MPP[12:11]=2'b11. Then REDIRECT.
- R_MSTATUS (mret): wen=1, addr 12'h300, data=status with MIE=status[7], MPIE=1, MPP=2'b11. Then REDIRECT.
- REDIRECT:
  - o_redirect_valid=1 and o_redirect_pc=target, held stable until i_redirect_ready.
  - On the handshake cycle: o_flush=1 for exactly that cycle, then IDLE.
- Outputs in states: o_stall=1 in every non-IDLE state. o_csr_wen=0 outside the W_*/R_* states. o_busy = (state != IDLE).
- Latency: trap entry is 4 cycles to the first redirect-valid cycle plus ready wait. mret is 2 cycles.
- Inputs other than i_redirect_ready are ignored while busy. No nested traps.
- ecall and mret asserted together (illegal) resolves to ecall.
- i_commit_valid=0: no action, even if an interrupt is pending.

Decomposition:
- Shared package trap_pkg:
  - CSR addresses (MSTATUS, MTVEC, MEPC, MCAUSE, MIE, MIP).
  - Cause constants.
  - mstatus bit indices (MIE=3, MPIE=7, MPP=12:11).
  - FSM state enum.
- One natural sub-module: mstatus_xform, a combinational entry/return mstatus rewrite selected by a mode bit.

Test Plan:
- ecall, pc=0x8000_0010, mstatus=0x8, mtvec=0x8000_0101, ready=1:
  - writes mepc=0x8000_0010, mcause=11, mstatus=0x1880 on consecutive cycles;
  - redirect_pc=0x8000_0100;
  - flush pulse 1 cycle; stall high for 4 cycles.
- mret, mepc=0x8000_0014, mstatus=0x1880:
  - one write mstatus=0x1888;
  - redirect to 0x8000_0014.
- mtip=1, MIE=1, MTIE=1 with ecall committing at pc=0x8000_0020:
  - mcause=0x8000_0000_0000_0007, mepc=0x8000_0020.
- Masking: mtip=1 with MIE=0, and mtip=1 with MTIE=0, over 10 commits:
  - no CSR write, no stall.
- Redirect back-pressure: ready low 5 cycles during REDIRECT:
  - valid/pc stable, no flush until ready, then flush 1 cycle.
- Reset: rst_n low asserted in W_MCAUSE:
  - all outputs 0 immediately;
  - after release, FSM IDLE and no mstatus write occurs.
